// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - BCD limits and hour display mapping for the time-of-day core
package clock_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [3:0] ten;
    logic [3:0] one;
    logic       pm;
  } hour_disp_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 12 h folds 0 to 12 and 13..23 down by 12; pm always follows the internal hour
  function automatic hour_disp_t hour_map(input logic [4:0] hour, input logic fmt24);
    hour_disp_t d;
    logic [4:0] h;
    if (fmt24)                h = hour;
    else if (hour == 5'd0)    h = 5'd12;
    else if (hour > 5'd12)    h = hour - 5'd12;
    else                      h = hour;
    if (h >= 5'd20) begin
      d.ten = 4'd2;
      d.one = 4'(h - 5'd20);
    end else if (h >= 5'd10) begin
      d.ten = 4'd1;
      d.one = 4'(h - 5'd10);
    end else begin
      d.ten = 4'd0;
      d.one = 4'(h);
    end
    d.pm = (hour >= 5'd12);
    return d;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - pushbutton synchronizer, debounce filter and press pulse
module key_debounce #(
  parameter int DEBOUNCE = 200_000
) (
  input  logic Clk,
  input  logic reset,
  input  logic key_n,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // level follows sync2 only after DEBOUNCE consecutive cycles of disagreement
  always_ff @(posedge Clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        level <= sync2;
        cnt   <= '0;
        pulse <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// rtl/bcd_timekeeper.sv - 1 Hz prescaler, BCD time counters, set mode and display registers
module bcd_timekeeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000,
  parameter int DEBOUNCE = 200_000
) (
  input  logic       ADC_CLK_10,
  input  logic       Reset,
  input  logic [1:0] SW,
  input  logic [1:0] KEY,
  output logic [3:0] hourten,
  output logic [3:0] hourone,
  output logic [3:0] mintens,
  output logic [3:0] minones,
  output logic       colon,
  output logic       pm,
  output logic       sec_tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic [7:0]    sec_bcd;
  logic [7:0]    min_bcd;
  logic [4:0]    hour;
  logic          set_mode;
  logic          tick;
  logic          tick_d;
  logic          min_pulse;
  logic          hour_pulse;
  hour_disp_t    disp;
  hour_disp_t    disp_rst;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_min (
    .Clk   (ADC_CLK_10),
    .reset (Reset),
    .key_n (KEY[0]),
    .pulse (min_pulse)
  );

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_hour (
    .Clk   (ADC_CLK_10),
    .reset (Reset),
    .key_n (KEY[1]),
    .pulse (hour_pulse)
  );

  assign set_mode = SW[1];
  assign tick     = !set_mode && (presc == PW'(TICK_DIV - 1));
  assign disp     = hour_map(hour, SW[0]);
  assign disp_rst = hour_map(5'd0, SW[0]);

  always_ff @(posedge ADC_CLK_10) begin
    if (Reset) begin
      presc   <= '0;
      sec_bcd <= 8'h00;
      min_bcd <= 8'h00;
      hour    <= 5'd0;
      tick_d  <= 1'b0;
    end else begin
      tick_d <= tick;
      if (set_mode) begin
        // holding presc at 0 makes the first tick after set mode a full second away
        presc   <= '0;
        sec_bcd <= 8'h00;
        if (min_pulse)  min_bcd <= bcd_inc(min_bcd, MIN_MAX);
        if (hour_pulse) hour    <= (hour == HOUR_MAX) ? 5'd0 : hour + 5'd1;
      end else if (tick) begin
        presc   <= '0;
        sec_bcd <= bcd_inc(sec_bcd, SEC_MAX);
        if (sec_bcd == SEC_MAX) begin
          min_bcd <= bcd_inc(min_bcd, MIN_MAX);
          if (min_bcd == MIN_MAX) hour <= (hour == HOUR_MAX) ? 5'd0 : hour + 5'd1;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // sec_tick is delayed to line up with the display showing the new second
  always_ff @(posedge ADC_CLK_10) begin
    if (Reset) begin
      hourten  <= disp_rst.ten;
      hourone  <= disp_rst.one;
      mintens  <= 4'd0;
      minones  <= 4'd0;
      pm       <= 1'b0;
      colon    <= 1'b1;
      sec_tick <= 1'b0;
    end else begin
      hourten  <= disp.ten;
      hourone  <= disp.one;
      mintens  <= min_bcd[7:4];
      minones  <= min_bcd[3:0];
      pm       <= disp.pm;
      colon    <= set_mode || (presc < PW'(TICK_DIV / 2));
      sec_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb/tb_bcd_timekeeper.sv - self-checking bench for bcd_timekeeper
module tb_bcd_timekeeper;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic [1:0] key;
  logic [3:0] ht, ho, mt, mo;
  logic       colon, pm, sec_tick;

  int n_cmp = 0;
  int n_fail = 0;
  int tick_count = 0;
  int base;

  logic [17:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    int         nh;
    int         nm;
    logic       fmt;
    logic [3:0] ht, ho, mt, mo;
    logic       pm;
  } vec_t;
  vec_t tbl[9];

  bcd_timekeeper #(.TICK_DIV(TD), .DEBOUNCE(DB)) dut (
    .ADC_CLK_10 (clk),
    .Reset      (rst),
    .SW         (sw),
    .KEY        (key),
    .hourten    (ht),
    .hourone    (ho),
    .mintens    (mt),
    .minones    (mo),
    .colon      (colon),
    .pm         (pm),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sec_tick === 1'b1) tick_count <= tick_count + 1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string nm, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d, input logic p, input logic cl);
    exp_q.push_back({a, b, c, d, p, cl});
    name_q.push_back(nm);
  endtask

  task automatic check_pop();
    logic [17:0] e;
    logic [17:0] a;
    string nm;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got no expected entry, want one");
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a  = {ht, ho, mt, mo, pm, colon};
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h%h:%h%h pm=%b colon=%b, want %h%h:%h%h pm=%b colon=%b", nm,
               a[17:14], a[13:10], a[9:6], a[5:2], a[1], a[0],
               e[17:14], e[13:10], e[9:6], e[5:2], e[1], e[0]);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] s);
    sw  = s;
    key = 2'b11;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic press(input int nh, input int nm, input int hold);
    int n;
    n = (nh > nm) ? nh : nm;
    for (int i = 0; i < n; i++) begin
      key = {(i < nh) ? 1'b0 : 1'b1, (i < nm) ? 1'b0 : 1'b1};
      cyc(hold);
      key = 2'b11;
      cyc(7);
    end
  endtask

  initial begin
    tbl[0] = '{0,  0,  1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0};
    tbl[1] = '{0,  0,  1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0};
    tbl[2] = '{13, 5,  1'b0, 4'd0, 4'd1, 4'd0, 4'd5, 1'b1};
    tbl[3] = '{13, 5,  1'b1, 4'd1, 4'd3, 4'd0, 4'd5, 1'b1};
    tbl[4] = '{12, 0,  1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1};
    tbl[5] = '{1,  30, 1'b0, 4'd0, 4'd1, 4'd3, 4'd0, 1'b0};
    tbl[6] = '{11, 59, 1'b0, 4'd1, 4'd1, 4'd5, 4'd9, 1'b0};
    tbl[7] = '{23, 7,  1'b0, 4'd1, 4'd1, 4'd0, 4'd7, 1'b1};
    tbl[8] = '{20, 10, 1'b1, 4'd2, 4'd0, 4'd1, 4'd0, 1'b1};

    rst = 1'b1;
    sw  = 2'b01;
    key = 2'b11;

    // reset state in both formats
    cyc(2);
    push("reset_24h", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    check_pop();
    rst = 1'b0;
    sw  = 2'b00;
    cyc(1);
    push("reset_12h", 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1);
    check_pop();

    // minute rollover: 60 ticks in 240 cycles
    do_reset(2'b01);
    base = tick_count;
    cyc(242);
    check_val("tick_count_240", tick_count - base, 60);
    push("minute_rollover", 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1);
    check_pop();

    // table of set-mode values and display formats
    for (int i = 0; i < 9; i++) begin
      do_reset({1'b1, tbl[i].fmt});
      press(tbl[i].nh, tbl[i].nm, 4);
      push($sformatf("table_%0d", i), tbl[i].ht, tbl[i].ho, tbl[i].mt, tbl[i].mo, tbl[i].pm, 1'b1);
      check_pop();
    end

    // day rollover from 23:59:00
    do_reset(2'b11);
    press(23, 59, 4);
    push("set_2359", 4'd2, 4'd3, 4'd5, 4'd9, 1'b1, 1'b1);
    check_pop();
    sw = 2'b01;
    cyc(239);
    push("before_midnight", 4'd2, 4'd3, 4'd5, 4'd9, 1'b1, 1'b0);
    check_pop();
    cyc(2);
    push("midnight_24h", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    check_pop();
    sw = 2'b00;
    cyc(1);
    push("midnight_12h", 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1);
    check_pop();

    // debounce, simultaneous keys and set-mode minute wrap
    do_reset(2'b11);
    key = 2'b10;
    cyc(2);
    key = 2'b11;
    cyc(8);
    push("glitch_rejected", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    check_pop();
    key = 2'b10;
    cyc(10);
    key = 2'b11;
    cyc(7);
    push("long_hold_once", 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1);
    check_pop();
    press(1, 1, 4);
    push("both_keys", 4'd0, 4'd1, 4'd0, 4'd2, 1'b0, 1'b1);
    check_pop();
    press(0, 57, 4);
    push("set_0159", 4'd0, 4'd1, 4'd5, 4'd9, 1'b0, 1'b1);
    check_pop();
    press(0, 1, 4);
    push("min_wrap_no_carry", 4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b1);
    check_pop();

    // reset in the tick cycle at 00:03
    do_reset(2'b01);
    cyc(721);
    push("run_0003", 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);
    check_pop();
    cyc(2);
    push("colon_low_half", 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
    check_pop();
    rst = 1'b1;
    cyc(1);
    push("reset_mid_count", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    check_pop();
    check_val("no_tick_at_reset", int'(sec_tick), 0);
    rst = 1'b0;
    cyc(1);
    check_val("no_tick_after_reset", int'(sec_tick), 0);
    push("after_reset_mid", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    check_pop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_timekeeper.md
# bcd_timekeeper

Time-of-day core for the EENG 220 clock. Divides `ADC_CLK_10` down to a 1 Hz tick and keeps seconds, minutes and hours. Presents the time as four BCD digits (`hourten`, `hourone`, `mintens`, `minones`) for the multiplexed 7-segment display driver, plus colon-blink and PM indicators. Also implements time setting from the two board pushbuttons.

## Interface
Parameters:
- `TICK_DIV`, default 10_000_000: clock cycles per second (10 MHz board clock).
- `DEBOUNCE`, default 200_000: stable cycles required to accept a key level (20 ms).

Ports:
- `ADC_CLK_10` in 1: the single clock; all state is on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `SW` in 2: `SW[0]` selects the display format, 1 = 24 h and 0 = 12 h. `SW[1]` = 1 selects set mode.
- `KEY` in 2: active-low pushbuttons, asynchronous to the clock. `KEY[0]` increments minutes; `KEY[1]` increments hours.
- `hourten`, `hourone`, `mintens`, `minones` out 4 each: BCD display digits, registered.
- `colon` out 1: colon segment enable, registered.
- `pm` out 1: high for internal hours 12–23, registered.
- `sec_tick` out 1: one-cycle pulse on each seconds increment.

## Operation
- **State registers:**
  - `presc`: 0..TICK_DIV-1.
  - `sec`: BCD tens and ones, 00..59.
  - `min`: BCD tens and ones, 00..59.
  - `hour`: 5-bit binary, 0..23.
- **Run mode (`SW[1]` = 0):**
  - `presc` increments every cycle. At TICK_DIV-1 it wraps to 0 and asserts the tick.
  - On each tick `sec` increments with BCD carry: ones 9→0 carries into tens, and 59→00 carries into `min`.
  - `min` 59→00 carries into `hour`. `hour` 23→0 wraps with no further carry.
  - KEY pulses are ignored.
- **Set mode (`SW[1]` = 1):**
  - `presc` and `sec` are held at 0, and no ticks occur.
  - A minute pulse increments `min` with BCD wrap 59→00 and no carry into `hour`.
  - An hour pulse increments `hour` with wrap 23→0.
  - If both pulses occur in the same cycle, both are applied.
- **Leaving set mode:** the next tick arrives exactly TICK_DIV cycles later.
- **Key conditioning:**
  - Each KEY bit passes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized input has differed from it for DEBOUNCE consecutive cycles.
  - A debounced 1→0 transition emits one 1-cycle pulse. Releases produce nothing, and holding a key gives exactly one pulse.
- **Display mapping (combinational from state, then registered):**
  - 24 h: hour digits are the BCD of `hour`.
  - 12 h: `hour` 0 displays 12, 1–12 display as-is, 13–23 display `hour`-12. `hourten` is 0 or 1.
  - Minute digits always come directly from `min`.
  - Changing `SW[0]` changes only the outputs, from the next cycle; no state is altered.
- **`colon`:** in run mode, 1 while `presc` < TICK_DIV/2 and 0 otherwise. In set mode it is held at 1.
- **Reset:**
  - Time and `presc` clear to 00:00:00, and debouncers clear to the released level (1).
  - Outputs after reset: digits 0,0,0,0 in 24 h, or 1,2,0,0 in 12 h; `pm` = 0; `colon` = 1; `sec_tick` = 0.
  - Reset asserted mid-operation takes effect on the next edge and overrides ticks and key pulses.

## Timing
- **Tick latency:** the tick occurs in the cycle where `presc` = TICK_DIV-1. The new `sec`/`min`/`hour` state is present after that edge, and the display outputs reflect it one cycle later.
- **`sec_tick` alignment:** asserted in the same cycle the outputs show the new time.
- **Key latency:** from a clean press at `KEY` to the state update is 2 synchronizer cycles + DEBOUNCE + 1. Outputs update one cycle after that.
- **Press duration:** presses shorter than DEBOUNCE cycles are rejected.
- **Throughput:** at most one increment per counter per cycle.

## Structure
- **Package `clock_pkg`:** BCD limit constants (`SEC_MAX` = 59, `MIN_MAX` = 59, `HOUR_MAX` = 23), and a function mapping `hour` plus the format bit to {`hourten`, `hourone`, `pm`}.
- **Sub-module `key_debounce`:** contains the synchronizer, debounce counter and falling-edge pulse, parameterized by DEBOUNCE. It is instantiated twice.
- **Everything else:** the prescaler, BCD counters and output registers live in `bcd_timekeeper`.

## Test plan
All scenarios use TICK_DIV = 4 and DEBOUNCE = 3.
1. **Reset:** `Reset` high for 2 cycles with `SW` = 01 → outputs 0,0,0,0, `pm` = 0, `colon` = 1. Switch `SW[0]` to 0 → 1,2,0,0 on the next cycle.
2. **Minute rollover:** run 240 cycles from reset → exactly 60 `sec_tick` pulses; digits 0,0,0,1 after the 60th.
3. **Day rollover:** set 23:59 via KEY (23 hour presses, 59 minute presses), release set mode, run 60 ticks → 24 h shows 0,0,0,0 with `pm` 1→0; 12 h shows 1,2,0,0.
4. **12 h mapping:** set `hour` = 13 and `min` = 05 with `SW[0]` = 0 → 0,1,0,5 with `pm` = 1. `hour` = 12 → 1,2 with `pm` = 1.
5. **Debounce and set wrap:**
   - A 2-cycle low glitch on `KEY[0]` → no change.
   - A 10-cycle hold → exactly one increment.
   - `min` 59 + press → 00 with `hour` unchanged.
   - `KEY[0]` and `KEY[1]` pressed in the same cycle → both counters increment.
6. **Reset mid-count:** run to 00:03:xx, assert `Reset` in the cycle where `presc` = 3 → next-edge state 00:00:00, no `sec_tick`.
